// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decoder and the immediate/target generator.
// The master side drives requests and out_ready; the slave side is the generator.
interface imm_gen_pipe_if #(
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mode;
  logic [JIDX_W-1:0] in_imm;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic              out_err;

  modport master (
    output in_valid, in_mode, in_imm, in_pc, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_imm, in_pc, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate and branch/jump target generator.
// S1 extends the immediate and forms pc+4; S2 does the branch add and target assembly.
module imm_gen_pipe #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);
  localparam int unsigned PC4_W = DATA_W + 1;
  localparam int unsigned SUM_W = DATA_W + 2;
  localparam int unsigned JLO_W = JIDX_W + 2;
  localparam logic [DATA_W-1:0] JUMP_LO_MASK = ~({DATA_W{1'b1}} << JLO_W);

  typedef enum logic [2:0] {
    MODE_ZERO   = 3'd0,
    MODE_SIGN   = 3'd1,
    MODE_HIGH   = 3'd2,
    MODE_BRANCH = 3'd3,
    MODE_JUMP   = 3'd4,
    MODE_PCWORD = 3'd5,
    MODE_RSV6   = 3'd6,
    MODE_RSV7   = 3'd7
  } mode_e;

  logic              s1_v_q,    s1_v_d;
  mode_e             s1_mode_q, s1_mode_d;
  logic [DATA_W-1:0] s1_ext_q,  s1_ext_d;
  logic [PC4_W-1:0]  s1_pc4_q,  s1_pc4_d;
  logic [DATA_W-1:0] s1_off_q,  s1_off_d;
  logic              s2_v_q,    s2_v_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_ovf_q,  s2_ovf_d;
  logic              s2_err_q,  s2_err_d;

  logic              s1_load_c;
  logic              s2_load_c;
  logic              accept_c;
  logic [IMM_W-1:0]  imm_c;
  logic [DATA_W-1:0] sext_c;
  logic [SUM_W-1:0]  br_sum_c;

  assign bus.in_ready  = !flush && (!s1_v_q || !s2_v_q || bus.out_ready);
  assign bus.out_valid = s2_v_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_ovf   = s2_ovf_q;
  assign bus.out_err   = s2_err_q;

  // Next-state for both stages; flush overrides the valid bits last.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_mode_d = s1_mode_q;
    s1_ext_d  = s1_ext_q;
    s1_pc4_d  = s1_pc4_q;
    s1_off_d  = s1_off_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_ovf_d  = s2_ovf_q;
    s2_err_d  = s2_err_q;

    imm_c     = bus.in_imm[IMM_W-1:0];
    sext_c    = {{(DATA_W-IMM_W){imm_c[IMM_W-1]}}, imm_c};
    // Carry-extended pc+4 plus sign-extended offset: the top two bits flag wrap either way.
    br_sum_c  = SUM_W'(s1_pc4_q) + {{2{s1_off_q[DATA_W-1]}}, s1_off_q};
    s2_load_c = !s2_v_q || bus.out_ready;
    s1_load_c = !s1_v_q || s2_load_c;
    accept_c  = bus.in_valid && bus.in_ready;

    if (s1_load_c) begin
      s1_v_d = accept_c;
      if (accept_c) begin
        s1_mode_d = mode_e'(bus.in_mode);
        s1_pc4_d  = PC4_W'(bus.in_pc) + PC4_W'(4);
        s1_off_d  = sext_c << 2;
        unique case (mode_e'(bus.in_mode))
          MODE_ZERO:   s1_ext_d = DATA_W'(imm_c);
          MODE_SIGN:   s1_ext_d = sext_c;
          MODE_HIGH:   s1_ext_d = DATA_W'({imm_c, {IMM_W{1'b0}}});
          MODE_JUMP:   s1_ext_d = DATA_W'(bus.in_imm);
          MODE_PCWORD: s1_ext_d = bus.in_pc;
          default:     s1_ext_d = '0;
        endcase
      end
    end

    if (s2_load_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_ovf_d = 1'b0;
        s2_err_d = 1'b0;
        unique case (s1_mode_q)
          MODE_ZERO, MODE_SIGN, MODE_HIGH: s2_data_d = s1_ext_q;
          MODE_BRANCH: begin
            s2_data_d = br_sum_c[DATA_W-1:0];
            s2_ovf_d  = |br_sum_c[SUM_W-1:DATA_W];
          end
          MODE_JUMP:   s2_data_d = (s1_pc4_q[DATA_W-1:0] & ~JUMP_LO_MASK) | (s1_ext_q << 2);
          MODE_PCWORD: s2_data_d = {2'b00, s1_ext_q[DATA_W-1:2]};
          default: begin
            s2_data_d = '0;
            s2_err_d  = 1'b1;
          end
        endcase
      end
    end

    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= MODE_ZERO;
      s1_ext_q  <= '0;
      s1_pc4_q  <= '0;
      s1_off_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_ovf_q  <= 1'b0;
      s2_err_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_mode_q <= s1_mode_d;
      s1_ext_q  <= s1_ext_d;
      s1_pc4_q  <= s1_pc4_d;
      s1_off_q  <= s1_off_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_ovf_q  <= s2_ovf_d;
      s2_err_q  <= s2_err_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vector table, backpressure/flush/reset sequences,
// and random traffic checked against an arithmetic reference model via a scoreboard.
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        err;
  } res_t;

  typedef struct {
    logic [2:0]  mode;
    logic [25:0] imm;
    logic [31:0] pc;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  imm_gen_pipe_if #(.JIDX_W(26), .DATA_W(32)) bus ();

  imm_gen_pipe #(.IMM_W(16), .JIDX_W(26), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;
  res_t        exp_q[$];
  int unsigned acc_cyc_q[$];
  int unsigned out_cyc_q[$];
  logic        chk_lat;
  logic        prev_hold;
  logic [31:0] prev_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the mode rules.
  function automatic res_t model(input logic [2:0] mode, input logic [25:0] imm, input logic [31:0] pc);
    res_t   r;
    longint m32 = 64'h1_0000_0000;
    longint i16 = longint'(imm[15:0]);
    longint s   = (i16 >= 32768) ? i16 - 65536 : i16;
    longint p   = longint'(pc);
    longint e;
    longint pc4;
    r = '0;
    case (mode)
      3'd0: r.data = 32'(i16);
      3'd1: r.data = 32'(s);
      3'd2: r.data = 32'(i16 * 65536);
      3'd3: begin
        e = p + 4 + s * 4;
        r.data = 32'(e);
        r.ovf  = (e < 0) || (e >= m32);
      end
      3'd4: begin
        pc4 = (p + 4) % m32;
        r.data = 32'((pc4 / 268435456) * 268435456 + longint'(imm) * 4);
      end
      3'd5: r.data = 32'(p / 4);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic [2:0] m, input logic [25:0] i, input logic [31:0] p,
                              input logic [31:0] d, input logic o, input logic e);
    vec_t v;
    v.mode = m; v.imm = i; v.pc = p;
    v.exp.data = d; v.exp.ovf = o; v.exp.err = e;
    return v;
  endfunction

  // One cycle: apply inputs, score the handshakes seen before the coming edge, advance.
  task automatic drive(input logic v, input logic [2:0] m, input logic [25:0] imm, input logic [31:0] pc,
                       input res_t e, input logic rdy, input logic fl, input logic rn, output logic acc);
    res_t got;
    int unsigned ac;
    bus.in_valid  = v;
    bus.in_mode   = m;
    bus.in_imm    = imm;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    rst_n         = rn;
    #1;
    acc = v & bus.in_ready & rn;
    if (prev_hold) chk("hold_data", 64'(bus.out_data), 64'(prev_data));
    if (bus.out_valid && rdy && !fl && rn) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(bus.out_valid), 64'(0));
      end else begin
        got = exp_q.pop_front();
        ac  = acc_cyc_q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(got.data));
        chk("out_ovf",  64'(bus.out_ovf),  64'(got.ovf));
        chk("out_err",  64'(bus.out_err),  64'(got.err));
        if (chk_lat) chk("latency", 64'(cyc - ac), 64'(2));
        out_cyc_q.push_back(cyc);
      end
    end
    prev_hold = bus.out_valid & !rdy & !fl & rn;
    prev_data = bus.out_data;
    if (acc) begin
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc);
    end
    if (fl || !rn) begin
      exp_q.delete();
      acc_cyc_q.delete();
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy, input int n);
    logic a;
    for (int k = 0; k < n; k++) drive(1'b0, 3'd0, 26'd0, 32'd0, '0, rdy, 1'b0, 1'b1, a);
  endtask

  task automatic drain();
    logic a;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      drive(1'b0, 3'd0, 26'd0, 32'd0, '0, 1'b1, 1'b0, 1'b1, a);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  vec_t        tbl[15];
  logic        acc;
  int unsigned n_acc;
  logic [25:0] bp_imm[3];
  logic [31:0] held;

  initial begin
    total = 0; bad = 0; cyc = 0; chk_lat = 1'b0; prev_hold = 1'b0; prev_data = '0;
    bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_imm = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; flush = 1'b0; rst_n = 1'b0;

    tbl[0]  = mk(3'd0, 26'h0008000, 32'h00000000, 32'h00008000, 1'b0, 1'b0);
    tbl[1]  = mk(3'd1, 26'h0008000, 32'h00000000, 32'hFFFF8000, 1'b0, 1'b0);
    tbl[2]  = mk(3'd2, 26'h0008000, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    tbl[3]  = mk(3'd2, 26'h0001234, 32'h00000000, 32'h12340000, 1'b0, 1'b0);
    tbl[4]  = mk(3'd3, 26'h000FFFF, 32'h00400000, 32'h00400000, 1'b0, 1'b0);
    tbl[5]  = mk(3'd3, 26'h0000000, 32'hFFFFFFFC, 32'h00000000, 1'b1, 1'b0);
    tbl[6]  = mk(3'd3, 26'h000FFFE, 32'h00000000, 32'hFFFFFFFC, 1'b1, 1'b0);
    tbl[7]  = mk(3'd3, 26'h0000010, 32'h00001000, 32'h00001044, 1'b0, 1'b0);
    tbl[8]  = mk(3'd4, 26'h0100000, 32'h10000000, 32'h10400000, 1'b0, 1'b0);
    tbl[9]  = mk(3'd4, 26'h3FFFFFF, 32'hF0000000, 32'hFFFFFFFC, 1'b0, 1'b0);
    tbl[10] = mk(3'd5, 26'h0000000, 32'h00400008, 32'h00100002, 1'b0, 1'b0);
    tbl[11] = mk(3'd6, 26'h0001234, 32'h12345678, 32'h00000000, 1'b0, 1'b1);
    tbl[12] = mk(3'd7, 26'h3FFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    tbl[13] = mk(3'd0, 26'h3FF1234, 32'h00000000, 32'h00001234, 1'b0, 1'b0);
    tbl[14] = mk(3'd1, 26'h2AB7FFF, 32'h00000000, 32'h00007FFF, 1'b0, 1'b0);

    // Reset values
    for (int k = 0; k < 3; k++) drive(1'b0, 3'd0, 26'd0, 32'd0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data",  64'(bus.out_data),  64'(0));
    chk("rst_out_ovf",   64'(bus.out_ovf),   64'(0));
    chk("rst_out_err",   64'(bus.out_err),   64'(0));
    idle(1'b1, 1);
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));

    // Directed table, back-to-back with out_ready high
    chk_lat = 1'b1;
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].mode, tbl[i].imm, tbl[i].pc, tbl[i].exp, 1'b1, 1'b0, 1'b1, acc);
      chk("tbl_accept", 64'(acc), 64'(1));
    end
    drain();
    chk_lat = 1'b0;

    // Backpressure: three requests against a stalled consumer
    bp_imm[0] = 26'h0000111; bp_imm[1] = 26'h0008222; bp_imm[2] = 26'h0000333;
    n_acc = 0;
    out_cyc_q.delete();
    for (int k = 0; k < 6; k++) begin
      drive(n_acc < 3, 3'd1, bp_imm[n_acc < 3 ? n_acc : 2], 32'd0,
            model(3'd1, bp_imm[n_acc < 3 ? n_acc : 2], 32'd0), 1'b0, 1'b0, 1'b1, acc);
      if (acc) n_acc++;
    end
    chk("bp_accepted",  64'(n_acc), 64'(2));
    chk("bp_in_ready",  64'(bus.in_ready), 64'(0));
    chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
    held = bus.out_data;
    idle(1'b0, 2);
    chk("bp_held_data", 64'(bus.out_data), 64'(held));
    for (int k = 0; k < 8; k++) begin
      drive(n_acc < 3, 3'd1, bp_imm[2], 32'd0, model(3'd1, bp_imm[2], 32'd0), 1'b1, 1'b0, 1'b1, acc);
      if (k == 0) chk("bp_release_accept", 64'(acc), 64'(1));
      if (acc) n_acc++;
    end
    chk("bp_out_count", 64'(out_cyc_q.size()), 64'(3));
    if (out_cyc_q.size() == 3) chk("bp_no_gap", 64'(out_cyc_q[2] - out_cyc_q[0]), 64'(2));
    drain();

    // Flush with two entries in flight and a request offered
    drive(1'b1, 3'd1, 26'h0008000, 32'd0, model(3'd1, 26'h0008000, 32'd0), 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3'd2, 26'h000ABCD, 32'd0, model(3'd2, 26'h000ABCD, 32'd0), 1'b0, 1'b0, 1'b1, acc);
    chk("fl_fill_valid", 64'(bus.out_valid), 64'(1));
    drive(1'b1, 3'd0, 26'h0005555, 32'd0, model(3'd0, 26'h0005555, 32'd0), 1'b1, 1'b1, 1'b1, acc);
    chk("fl_no_accept", 64'(acc), 64'(0));
    chk("fl_out_valid", 64'(bus.out_valid), 64'(0));
    for (int k = 0; k < 4; k++) begin
      idle(1'b1, 1);
      chk("fl_no_stale", 64'(bus.out_valid), 64'(0));
    end

    // Reset mid-stream
    drive(1'b1, 3'd1, 26'h0008000, 32'd0, model(3'd1, 26'h0008000, 32'd0), 1'b0, 1'b0, 1'b1, acc);
    drive(1'b1, 3'd3, 26'h000FFFE, 32'd0, model(3'd3, 26'h000FFFE, 32'd0), 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0, 1);
    drive(1'b1, 3'd1, 26'h0008000, 32'd0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mrst_out_data",  64'(bus.out_data),  64'(0));
    chk("mrst_out_ovf",   64'(bus.out_ovf),   64'(0));
    chk("mrst_out_err",   64'(bus.out_err),   64'(0));
    idle(1'b1, 1);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'(1));
    for (int k = 0; k < 3; k++) begin
      idle(1'b1, 1);
      chk("mrst_no_stale", 64'(bus.out_valid), 64'(0));
    end

    // Random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      logic        v, rdy, fl;
      logic [2:0]  m;
      logic [25:0] imm;
      logic [31:0] pc;
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 49) == 0);
      m   = 3'($urandom_range(0, 7));
      imm = 26'($urandom);
      case ($urandom_range(0, 2))
        0:       pc = 32'($urandom);
        1:       pc = 32'hFFFF0000 | 32'($urandom_range(0, 65535));
        default: pc = 32'($urandom_range(0, 65535));
      endcase
      drive(v, m, imm, pc, model(m, imm, pc), rdy, fl, 1'b1, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
